systolic_mm_engine: RTL
=======================

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning array rows (x lanes).
REQ-002 SHALL have parameter COLS, default 4, meaning array columns (w lanes).
REQ-003 SHALL have parameter NBITS, default 16, meaning operand and accumulator width.
REQ-004 SHALL have parameter DBITS, default 8, meaning fractional bits.
REQ-005 SHALL have parameter KMAX, default 16, meaning maximum reduction length.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst, input, 1, meaning synchronous active-low reset (rst=0 resets on the clk edge).
REQ-008 SHALL have ports start (input, 1, begin job), k_len (input, $clog2(KMAX+1), reduction length) and acc_mode (input, 1; 0 = clear accumulators, 1 = accumulate).
REQ-009 SHALL have ports op_x (input, ROWS*NBITS, row i at bits [i*NBITS +: NBITS]), op_w (input, COLS*NBITS, same packing), op_val (input, 1) and op_rdy (output, 1).
REQ-010 SHALL have ports out_data (output, NBITS), out_row (output, $clog2(ROWS)), out_col (output, $clog2(COLS)), out_val (output, 1) and out_rdy (input, 1).
REQ-011 SHALL have ports busy (output, 1, state != IDLE) and done (output, 1, one-cycle pulse).

Function
REQ-012 SHALL implement FSM states IDLE, FEED, FLUSH and DRAIN.
REQ-013 SHALL leave IDLE only on start=1; start SHALL be ignored outside IDLE.
- Transition on start to FEED, or to DRAIN if k_len=0.
- Latch k_len on the start cycle.
- Zero all accumulators on the start cycle when acc_mode=0.
REQ-014 SHALL drive op_rdy=1 only in FEED; a beat is op_val&op_rdy.
REQ-015 SHALL advance the array, skew registers and beat counter only on a beat in FEED; a cycle without a beat SHALL be a full stall with no state change.
REQ-016 SHALL delay row i's x by i advances and column j's w by j advances through internal skew registers, so that PE(i,j) sees matching k indices.
REQ-017 SHALL pass x right and w down one PE per advance; each PE SHALL do acc += (x*w) >>> DBITS.
- Multiply: signed two's complement, 2*NBITS product.
- Shift: arithmetic right.
- Result: truncated to NBITS.
- Accumulate: wraps modulo 2^NBITS; no saturation.
REQ-018 SHALL enter FLUSH after the k_len-th beat and stay there for exactly ROWS+COLS-2 cycles, advancing every cycle with zero inputs; when that count is 0, FLUSH SHALL last 1 cycle.
REQ-019 SHALL, in DRAIN, present accumulators in row-major order (0,0),(0,1),...,(ROWS-1,COLS-1), with out_val=1 and the matching out_row/out_col.
REQ-020 SHALL hold out_data, out_row and out_col stable while out_val&!out_rdy, and advance one element per out_val&out_rdy.
REQ-021 SHALL pulse done for one cycle on acceptance of the last element, and return to IDLE in the same cycle.
REQ-022 SHALL preserve accumulators after DRAIN, so that a following acc_mode=1 job adds to them.
REQ-023 SHALL produce its first out_val exactly k_len+(ROWS+COLS-2) advancing cycles after the start cycle when op_val is held high.

Reset
REQ-024 SHALL, on rst=0, force IDLE and zero all accumulators, skew registers, PE pipeline registers and counters.
REQ-025 SHALL, on rst=0, drive op_rdy=0, out_val=0, out_data=0, out_row=0, out_col=0, busy=0 and done=0.
REQ-026 SHALL apply reset identically in any state, including mid-FEED and mid-DRAIN; no partial results SHALL survive.

Structure
REQ-027 SHALL place the FSM state enum and the fixed-point multiply-shift function in shared package systolic_pkg.
REQ-028 SHALL instantiate sub-module systolic_pe_acc (MAC with clear and enable, forwarding x and w) ROWS*COLS times; the skew lines, FSM and drain mux SHALL stay in the top level.

Verification (ROWS=COLS=2, NBITS=16, DBITS=8; 1.0=0x0100)
REQ-029 SHALL cover: acc_mode=0, k_len=1, x=(1.0,2.0), w=(3.0,0.5) -> out 0x0300, 0x0080, 0x0600, 0x0100 in row-major order, then a done pulse.
REQ-030 SHALL cover: REQ-029 repeated with acc_mode=1 -> 0x0600, 0x0100, 0x0C00, 0x0200.
REQ-031 SHALL cover: k_len=3 with op_val low for 2 cycles between beats -> same results as an uninterrupted stream; op_rdy=0 outside FEED.
REQ-032 SHALL cover: out_rdy=0 for 3 cycles at element (0,1) -> out_data 0x0080 held stable with out_val=1, no element skipped.
REQ-033 SHALL cover: rst=0 during the 2nd FEED beat, then a REQ-029 job -> exact REQ-029 results; start asserted in FLUSH is ignored.
REQ-034 SHALL cover: x=127.0 (0x7F00), w=2.0 -> out_data 0xFE00 (wrap); k_len=0 after a clear -> four 0x0000 outputs.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg : FSM encoding and fixed-point multiply-shift shared by the
//                systolic matrix-multiply engine.            Revision 1.0
// ============================================================================
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // Operands arrive sign-extended to 32 bits; the caller truncates the result.
   function automatic logic signed [63:0] fx_mul_shift(
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input int                 dbits
   );
      logic signed [63:0] ae;
      logic signed [63:0] be;
      ae = 64'(a);
      be = 64'(b);
      return (ae * be) >>> dbits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe_acc.sv
`default_nettype none
// ============================================================================
// systolic_pe_acc : one processing element, fixed-point MAC that forwards its
//                   x operand right and its w operand down.   Revision 1.0
// ============================================================================
module systolic_pe_acc
   import systolic_pkg::*;
#(
   parameter int NBITS = 16,
   parameter int DBITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             clr_acc_i,
   input  logic [NBITS-1:0] x_i,
   input  logic [NBITS-1:0] w_i,
   output logic [NBITS-1:0] x_o,
   output logic [NBITS-1:0] w_o,
   output logic [NBITS-1:0] acc_o
);

   logic [NBITS-1:0] x_q;
   logic [NBITS-1:0] w_q;
   logic [NBITS-1:0] acc_q;
   logic [NBITS-1:0] acc_d;
   logic [NBITS-1:0] prod_w;

   assign prod_w = NBITS'(fx_mul_shift(32'(signed'(x_i)), 32'(signed'(w_i)), DBITS));
   assign acc_d  = acc_q + prod_w;

   always_ff @(posedge clk) begin
      if (!rst) begin
         x_q   <= '0;
         w_q   <= '0;
         acc_q <= '0;
      end else begin
         if (clr_acc_i) begin
            acc_q <= '0;
         end else if (en_i) begin
            acc_q <= acc_d;
         end
         if (clr_i) begin
            x_q <= '0;
            w_q <= '0;
         end else if (en_i) begin
            x_q <= x_i;
            w_q <= w_i;
         end
      end
   end

   assign x_o   = x_q;
   assign w_o   = w_q;
   assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/systolic_mm_engine.sv
`default_nettype none
// ============================================================================
// systolic_mm_engine : output-stationary ROWS x COLS systolic matrix-multiply
//                      engine with skewed feed, flush and row-major drain.
//                      Revision 1.0
// ============================================================================
module systolic_mm_engine
   import systolic_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int NBITS = 16,
   parameter int DBITS = 8,
   parameter int KMAX  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [$clog2(KMAX+1)-1:0] k_len,
   input  logic                      acc_mode,
   input  logic [ROWS*NBITS-1:0]     op_x,
   input  logic [COLS*NBITS-1:0]     op_w,
   input  logic                      op_val,
   output logic                      op_rdy,
   output logic [NBITS-1:0]          out_data,
   output logic [$clog2(ROWS)-1:0]   out_row,
   output logic [$clog2(COLS)-1:0]   out_col,
   output logic                      out_val,
   input  logic                      out_rdy,
   output logic                      busy,
   output logic                      done
);

   localparam int KW        = $clog2(KMAX+1);
   localparam int RW        = $clog2(ROWS);
   localparam int CW        = $clog2(COLS);
   localparam int FLUSH_CYC = (ROWS + COLS - 2 == 0) ? 1 : ROWS + COLS - 2;
   localparam int FW        = $clog2(FLUSH_CYC + 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

   state_e          state_q;
   state_e          state_d;
   logic [KW-1:0]   klen_q;
   logic [KW-1:0]   kcnt_q;
   logic [FW-1:0]   fcnt_q;
   logic [RW-1:0]   row_q;
   logic [CW-1:0]   col_q;

   logic            beat_w;
   logic            adv_w;
   logic            start_w;
   logic            last_beat_w;
   logic            last_elem_w;

   logic [NBITS-1:0] xin_w [ROWS];
   logic [NBITS-1:0] win_w [COLS];
   logic [NBITS-1:0] xo_w  [ROWS][COLS];
   logic [NBITS-1:0] wo_w  [ROWS][COLS];
   logic [NBITS-1:0] acc_w [ROWS][COLS];

   assign beat_w      = op_val & op_rdy;
   assign adv_w       = ((state_q == FEED) & beat_w) | (state_q == FLUSH);
   assign start_w     = (state_q == IDLE) & start;
   assign last_beat_w = ((kcnt_q + KW'(1)) == klen_q);
   assign last_elem_w = (row_q == ROW_LAST) & (col_q == COL_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (k_len == '0) ? DRAIN : FEED;
         FEED:    if (beat_w && last_beat_w) state_d = FLUSH;
         FLUSH:   if (fcnt_q == FLUSH_LAST) state_d = DRAIN;
         DRAIN:   if (out_rdy && last_elem_w) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are also gated by rst so the reset values appear while rst is low.
   always_comb begin
      op_rdy   = rst & (state_q == FEED);
      out_val  = rst & (state_q == DRAIN);
      busy     = rst & (state_q != IDLE);
      done     = out_val & out_rdy & last_elem_w;
      out_row  = out_val ? row_q : '0;
      out_col  = out_val ? col_q : '0;
      out_data = out_val ? acc_w[row_q][col_q] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         klen_q <= '0;
         kcnt_q <= '0;
         fcnt_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  klen_q <= k_len;
                  kcnt_q <= '0;
                  fcnt_q <= '0;
                  row_q  <= '0;
                  col_q  <= '0;
               end
            end
            FEED:  if (beat_w) kcnt_q <= kcnt_q + KW'(1);
            FLUSH: fcnt_q <= fcnt_q + FW'(1);
            DRAIN: begin
               if (out_rdy) begin
                  if (col_q == COL_LAST) begin
                     col_q <= '0;
                     row_q <= row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Row i is delayed by i advances so every PE pairs operands of the same k.
   for (genvar i = 0; i < ROWS; i++) begin : g_xskew
      logic [NBITS-1:0] src_w;
      assign src_w = (state_q == FEED) ? op_x[i*NBITS +: NBITS] : '0;
      if (i == 0) begin : g_direct
         assign xin_w[i] = src_w;
      end else begin : g_delay
         logic [NBITS-1:0] sk_q [i];
         always_ff @(posedge clk) begin
            if (!rst || start_w) begin
               for (int s = 0; s < i; s++) sk_q[s] <= '0;
            end else if (adv_w) begin
               sk_q[0] <= src_w;
               for (int s = 1; s < i; s++) sk_q[s] <= sk_q[s-1];
            end
         end
         assign xin_w[i] = sk_q[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_wskew
      logic [NBITS-1:0] src_w;
      assign src_w = (state_q == FEED) ? op_w[j*NBITS +: NBITS] : '0;
      if (j == 0) begin : g_direct
         assign win_w[j] = src_w;
      end else begin : g_delay
         logic [NBITS-1:0] sk_q [j];
         always_ff @(posedge clk) begin
            if (!rst || start_w) begin
               for (int s = 0; s < j; s++) sk_q[s] <= '0;
            end else if (adv_w) begin
               sk_q[0] <= src_w;
               for (int s = 1; s < j; s++) sk_q[s] <= sk_q[s-1];
            end
         end
         assign win_w[j] = sk_q[j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         logic [NBITS-1:0] pe_x_w;
         logic [NBITS-1:0] pe_w_w;
         if (j == 0) begin : g_xedge
            assign pe_x_w = xin_w[i];
         end else begin : g_xlink
            assign pe_x_w = xo_w[i][j-1];
         end
         if (i == 0) begin : g_wedge
            assign pe_w_w = win_w[j];
         end else begin : g_wlink
            assign pe_w_w = wo_w[i-1][j];
         end
         systolic_pe_acc #(
            .NBITS (NBITS),
            .DBITS (DBITS)
         ) u_pe (
            .clk       (clk),
            .rst       (rst),
            .en_i      (adv_w),
            .clr_i     (start_w),
            .clr_acc_i (start_w & ~acc_mode),
            .x_i       (pe_x_w),
            .w_i       (pe_w_w),
            .x_o       (xo_w[i][j]),
            .w_o       (wo_w[i][j]),
            .acc_o     (acc_w[i][j])
         );
      end
   end

endmodule
`default_nettype wire
